// File: rtl/ins_fetcher.sv
// Instruction fetch: PC register, direct-mapped one-word-per-line I-cache, single-word miss fetch.
// Define ICACHE_EN to build the cache; without it every fetch goes through the memory controller.
module ins_fetcher #(
    parameter logic [31:0] RESET_PC       = 32'h0,
    parameter int          ICACHE_IDX_BIT = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        dec_stall,
    input  logic [31:0] dec_next_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_addr,
    input  logic        rob_clear,
    input  logic [31:0] rob_restart_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data
);
    localparam int LINES = 1 << ICACHE_IDX_BIT;
    localparam int TAG_W = 32 - (ICACHE_IDX_BIT + 2);

    typedef enum logic {LOOKUP, MISS} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        flush_pend, flush_pend_nxt;
    logic        inst_valid_nxt, mem_req_nxt;
    logic [31:0] inst_nxt, inst_addr_nxt, mem_addr_nxt;

    logic        consume;
    logic [31:0] fa;
    logic        hit;
    logic [31:0] line_data;
    logic        fill_en;

    assign consume = inst_valid && !dec_stall;
    assign fa      = consume ? dec_next_pc : pc;

`ifdef ICACHE_EN
    logic [LINES-1:0]          line_vld;
    logic [TAG_W-1:0]          tag_mem [LINES];
    logic [31:0]               data_mem [LINES];
    logic [ICACHE_IDX_BIT-1:0] fa_idx, fill_idx;

    assign fa_idx    = fa[ICACHE_IDX_BIT+1:2];
    assign fill_idx  = mem_addr[ICACHE_IDX_BIT+1:2];
    assign hit       = line_vld[fa_idx] && (tag_mem[fa_idx] == fa[31:ICACHE_IDX_BIT+2]);
    assign line_data = data_mem[fa_idx];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            line_vld <= '0;
        end else if (rdy_in && fill_en) begin
            line_vld[fill_idx] <= 1'b1;
        end
    end

    // Tag/data are plain storage; only the valid bits need reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in && fill_en) begin
            tag_mem[fill_idx]  <= mem_addr[31:ICACHE_IDX_BIT+2];
            data_mem[fill_idx] <= mem_data;
        end
    end
`else
    logic unused_fill;

    assign hit         = 1'b0;
    assign line_data   = '0;
    assign unused_fill = fill_en;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= LOOKUP;
            pc         <= RESET_PC;
            flush_pend <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_addr  <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
        end else if (rdy_in) begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            flush_pend <= flush_pend_nxt;
            inst_valid <= inst_valid_nxt;
            inst       <= inst_nxt;
            inst_addr  <= inst_addr_nxt;
            mem_req    <= mem_req_nxt;
            mem_addr   <= mem_addr_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        flush_pend_nxt = flush_pend;
        inst_valid_nxt = inst_valid;
        inst_nxt       = inst;
        inst_addr_nxt  = inst_addr;
        mem_req_nxt    = mem_req;
        mem_addr_nxt   = mem_addr;
        fill_en        = 1'b0;

        case (state)
            LOOKUP: begin
                if (rob_clear) begin
                    inst_valid_nxt = 1'b0;
                    pc_nxt         = rob_restart_pc;
                end else if (inst_valid && dec_stall) begin
                    inst_valid_nxt = inst_valid;
                end else if (hit) begin
                    inst_nxt       = line_data;
                    inst_addr_nxt  = fa;
                    inst_valid_nxt = 1'b1;
                    pc_nxt         = fa;
                end else begin
                    inst_valid_nxt = 1'b0;
                    pc_nxt         = fa;
                    mem_addr_nxt   = fa;
                    mem_req_nxt    = 1'b1;
                    state_nxt      = MISS;
                end
            end
            MISS: begin
                // The request is never aborted; a flush only suppresses delivery.
                if (mem_done) begin
                    fill_en        = 1'b1;
                    mem_req_nxt    = 1'b0;
                    state_nxt      = LOOKUP;
                    flush_pend_nxt = 1'b0;
                    if (!flush_pend && !rob_clear) begin
                        inst_nxt       = mem_data;
                        inst_addr_nxt  = mem_addr;
                        inst_valid_nxt = 1'b1;
                    end else if (rob_clear) begin
                        pc_nxt = rob_restart_pc;
                    end
                end else if (rob_clear) begin
                    pc_nxt         = rob_restart_pc;
                    flush_pend_nxt = 1'b1;
                end
            end
            default: state_nxt = LOOKUP;
        endcase
    end
endmodule

// File: tb/tb_ins_fetcher.sv
// Directed bench for ins_fetcher; hit expectations depend on whether ICACHE_EN is defined.
`timescale 1ns/1ps
module tb_ins_fetcher;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, dec_stall, rob_clear, mem_done;
    logic [31:0] dec_next_pc, rob_restart_pc, mem_data;
    logic        inst_valid, mem_req;
    logic [31:0] inst, inst_addr, mem_addr;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

`ifdef ICACHE_EN
    localparam bit CACHED = 1'b1;
`else
    localparam bit CACHED = 1'b0;
`endif

    ins_fetcher #(.RESET_PC(32'h0), .ICACHE_IDX_BIT(6)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .dec_stall(dec_stall), .dec_next_pc(dec_next_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_addr(inst_addr),
        .rob_clear(rob_clear), .rob_restart_pc(rob_restart_pc),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_done(mem_done), .mem_data(mem_data)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Memory contents: address 0 holds 32'h00000013 (nop).
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h13 | (a << 12);
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a request, checks its address, answers 3 cycles later.
    task automatic serve(input logic [31:0] a);
        for (int i = 0; i < 10 && mem_req !== 1'b1; i++) tick();
        chk("mem_req_raised", {31'b0, mem_req}, 32'd1);
        chk("mem_addr", mem_addr, a);
        tick();
        tick();
        mem_done = 1'b1;
        mem_data = word_at(a);
        tick();
        mem_done = 1'b0;
        mem_data = '0;
    endtask

    task automatic expect_inst(input logic [31:0] a);
        chk("inst_valid", {31'b0, inst_valid}, 32'd1);
        chk("inst_addr", inst_addr, a);
        chk("inst", inst, word_at(a));
        chk("mem_req_idle", {31'b0, mem_req}, 32'd0);
    endtask

    task automatic settle(input logic [31:0] a, input bit in_cache);
        tick();
        dec_stall = 1'b1;
        if (!(in_cache && CACHED)) serve(a);
        expect_inst(a);
    endtask

    task automatic go(input logic [31:0] a, input bit in_cache);
        dec_stall   = 1'b0;
        dec_next_pc = a;
        settle(a, in_cache);
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; dec_stall = 1'b1; dec_next_pc = '0;
        rob_clear = 1'b0; rob_restart_pc = '0; mem_done = 1'b0; mem_data = '0;

        tick();
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_addr", inst_addr, 32'h0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        rst_in = 1'b0;

        // Cold start from RESET_PC.
        serve(32'h0);
        expect_inst(32'h0);
        chk("cold_inst_nop", inst, 32'h0000_0013);

        go(32'h4, 1'b0);
        go(32'h8, 1'b0);
        go(32'h40, 1'b0);
        go(32'h0, 1'b1);

`ifdef ICACHE_EN
        // Back-to-back hits, one per cycle.
        dec_stall = 1'b0;
        dec_next_pc = 32'h4; tick(); expect_inst(32'h4);
        dec_next_pc = 32'h8; tick(); expect_inst(32'h8);
        dec_next_pc = 32'h0; tick(); expect_inst(32'h0);
        dec_stall = 1'b1;
`endif

        // Stall hold: next_pc must be ignored while stalled.
        go(32'h4, 1'b1);
        dec_next_pc = 32'h80;
        repeat (3) tick();
        chk("stall_valid", {31'b0, inst_valid}, 32'd1);
        chk("stall_addr", inst_addr, 32'h4);
        chk("stall_inst", inst, word_at(32'h4));
        chk("stall_no_req", {31'b0, mem_req}, 32'd0);
        go(32'h40, 1'b1);

        // Flush during miss.
        dec_stall = 1'b0; dec_next_pc = 32'h100;
        tick();
        dec_stall = 1'b1;
        chk("flush_req", {31'b0, mem_req}, 32'd1);
        chk("flush_addr", mem_addr, 32'h100);
        rob_clear = 1'b1; rob_restart_pc = 32'h8;
        tick();
        rob_clear = 1'b0;
        chk("flush_req_held", {31'b0, mem_req}, 32'd1);
        chk("flush_addr_held", mem_addr, 32'h100);
        chk("flush_no_valid", {31'b0, inst_valid}, 32'd0);
        tick();
        mem_done = 1'b1; mem_data = word_at(32'h100);
        tick();
        mem_done = 1'b0; mem_data = '0;
        chk("flush_drop_valid", {31'b0, inst_valid}, 32'd0);
        chk("flush_req_drop", {31'b0, mem_req}, 32'd0);
        settle(32'h8, 1'b1);
        go(32'h100, 1'b1);

        // Conflict eviction: 0x0 and 0x100 share index 0.
        go(32'h0, 1'b0);
        go(32'h100, 1'b0);

        // Async reset in the middle of a miss.
        dec_stall = 1'b0; dec_next_pc = 32'h200;
        tick();
        dec_stall = 1'b1;
        chk("pre_rst_req", {31'b0, mem_req}, 32'd1);
        chk("pre_rst_addr", mem_addr, 32'h200);
        #2 rst_in = 1'b1;
        #1;
        chk("async_rst_req", {31'b0, mem_req}, 32'd0);
        chk("async_rst_addr", mem_addr, 32'h0);
        chk("async_rst_valid", {31'b0, inst_valid}, 32'd0);
        rdy_in = 1'b0;
        #1 rst_in = 1'b0;

        // rdy_in low: nothing moves, even with mem_done pulsing.
        mem_done = 1'b1; mem_data = 32'hdead_beef;
        tick(); tick();
        mem_done = 1'b0; mem_data = '0;
        chk("rdy_lookup_req", {31'b0, mem_req}, 32'd0);
        chk("rdy_lookup_valid", {31'b0, inst_valid}, 32'd0);
        rdy_in = 1'b1;
        tick();
        chk("rst_pc_req", {31'b0, mem_req}, 32'd1);
        chk("rst_pc_addr", mem_addr, 32'h0);
        rdy_in = 1'b0;
        mem_done = 1'b1; mem_data = 32'hdead_beef;
        tick(); tick();
        mem_done = 1'b0; mem_data = '0;
        chk("rdy_miss_req", {31'b0, mem_req}, 32'd1);
        chk("rdy_miss_valid", {31'b0, inst_valid}, 32'd0);
        rdy_in = 1'b1;
        serve(32'h0);
        expect_inst(32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/ins_fetcher.md
Name: ins_fetcher

Overview:
Instruction fetch stage directly upstream of the decoder. Holds the PC and looks up a direct-mapped, one-word-per-line instruction cache. On a miss it fetches one 32-bit word through the memory controller handshake. It presents one instruction per cycle to the decoder and follows the decoder's stall and next_PC, plus ROB flush redirects.

Parameters:
RESET_PC, 32'h0, PC value after reset.
ICACHE_IDX_BIT, 6, log2 of the number of cache lines (64 lines). Tag is PC[31:ICACHE_IDX_BIT+2].

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset, asynchronous, active-high
rdy_in  in  1  global ready; when low, all state holds
dec_stall  in  1  decoder is_stall; the current instruction is not consumed
dec_next_pc  in  32  decoder next_PC, valid when the instruction is consumed
inst_valid  out  1  instruction output valid (drives decoder inst_input)
inst  out  32  instruction word
inst_addr  out  32  address of inst
rob_clear  in  1  ROB flush/redirect
rob_restart_pc  in  32  redirect target, valid with rob_clear
mem_req  out  1  word fetch request, level, held until mem_done
mem_addr  out  32  word fetch address, word aligned
mem_done  in  1  one-cycle pulse; mem_data valid
mem_data  in  32  fetched word

Behaviour:
- Reset (async): pc=RESET_PC, state=LOOKUP, all cache valid bits 0, flush_pend=0. Outputs: inst_valid=0, inst=0, inst_addr=0, mem_req=0, mem_addr=0.
- All updates happen only when rdy_in=1. Otherwise every register holds, including mem_req.
- consume = inst_valid && !dec_stall.
- fa (fetch address, combinational) = consume ? dec_next_pc : pc.
- Cache read is combinational on fa: hit = valid[idx(fa)] && tag[idx(fa)] == tag(fa).
- State LOOKUP, evaluated in priority order:
  - rob_clear: inst_valid<=0, pc<=rob_restart_pc, stay in LOOKUP. Any lookup result that cycle is discarded.
  - else if inst_valid && dec_stall: hold all outputs.
  - else if hit: inst<=line data, inst_addr<=fa, inst_valid<=1, pc<=fa. Throughput is 1 instruction per cycle on consecutive hits.
  - else (miss): inst_valid<=0, pc<=fa, mem_addr<=fa, mem_req<=1, go to MISS.
- State MISS: mem_req stays 1 and mem_addr is stable until mem_done.
  - rob_clear without mem_done: pc<=rob_restart_pc, flush_pend<=1, remain in MISS. The in-flight request is never aborted.
  - On mem_done:
    - Always write line idx(mem_addr) with valid=1, tag, mem_data. The data is correct for that address even if a flush occurred.
    - mem_req<=0 and go to LOOKUP.
    - If flush_pend=0 and no rob_clear this cycle: inst<=mem_data, inst_addr<=mem_addr, inst_valid<=1.
    - Otherwise inst_valid stays 0, and pc takes rob_restart_pc if rob_clear is asserted this cycle. flush_pend<=0.
  - inst_valid is 0 throughout MISS.
- Miss latency: request in the cycle after the lookup, instruction valid in the cycle after mem_done.
- mem_req drops in the cycle after mem_done. A new request can be raised from the next LOOKUP cycle, so there is at least one idle cycle between requests.
- Low 2 bits of PC/fa are assumed 0. The address is passed as-is and no misalignment trap is raised.
- Index wrap: a conflicting address evicts the line. No write-back is needed (read-only cache).

Optional Feature:
- ICACHE_EN defined: cache as described.
- ICACHE_EN undefined: no tag/data/valid arrays. hit is constant 0, so every fetch takes the MISS path and nothing is written on mem_done. Ports are unchanged, and all handshake and flush rules still hold.

Test Plan:
- Cold start, RESET_PC=0, memory returns 32'h00000013 after 3 cycles: mem_req=1 with mem_addr=0; after mem_done, inst_valid=1, inst=32'h00000013, inst_addr=0.
- Warm loop, lines 0x0/0x4/0x8 cached, dec_stall=0, dec_next_pc=addr+4 then 0x0: inst_addr sequence 0x0, 0x4, 0x8, 0x0 on consecutive cycles, mem_req stays 0.
- Stall hold: inst_valid=1 at 0x4, dec_stall=1 for 3 cycles: inst and inst_addr unchanged; on release with dec_next_pc=0x40 (cached), inst_addr=0x40 next cycle.
- Flush in miss: miss on 0x100, rob_clear with rob_restart_pc=0x8 (cached) before mem_done: mem_addr stays 0x100; on mem_done line 0x100 is filled, inst_valid stays 0; next cycle inst_addr=0x8 valid; a later fetch of 0x100 hits.
- Conflict eviction (ICACHE_IDX_BIT=6): fetch 0x0 then 0x100 (same index): the second fetch misses; refetching 0x0 misses again with mem_addr=0x0.
- Async reset mid-miss plus rdy_in=0 hold: mem_req falls immediately on rst_in, pc returns to RESET_PC; with rdy_in=0 and mem_done pulsed, no state change.
